// File: rtl/pt2272_pkg.sv
// Shared symbol codes, frame geometry and sequencer state type for the PT2272 receive path.
package pt2272_pkg;

    localparam logic [1:0] SYM_0    = 2'b00;
    localparam logic [1:0] SYM_1    = 2'b11;
    localparam logic [1:0] SYM_F    = 2'b10;
    localparam logic [1:0] SYM_SYNC = 2'b01;

    localparam int unsigned FRAME_ADDR_SYMS = 8;
    localparam int unsigned FRAME_DATA_SYMS = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        TAIL    = 2'd2
    } seq_state_t;

    // A floating trit must be F; a fixed trit must be the doubled address bit.
    function automatic logic trit_match(input logic [1:0] code, input logic val, input logic f);
        return f ? (code == SYM_F) : (code == {val, val});
    endfunction

endpackage

// File: rtl/pt2272_hold_timer.sv
// Hold-time counter: runs while dv is high, reloads on every confirmation.
module pt2272_hold_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic osc_clk,
    input  logic reset,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q;

    assign expired = run && (cnt_q == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (reload) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pt2272_frame_sequencer.sv
// PT2272 frame assembly, address check, multi-frame confirmation and D/dv output control.
module pt2272_frame_sequencer
    import pt2272_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter bit          LATCH          = 1'b0
) (
    input  logic       osc_clk,
    input  logic       reset,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    input  logic [7:0] addr_val,
    input  logic [7:0] addr_f,
    output logic [3:0] D,
    output logic       dv,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] CONF     = 3'(CONFIRM_FRAMES);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_ADDR_SYMS + FRAME_DATA_SYMS - 1);

    seq_state_t                 state_q;
    logic [3:0]                 idx_q;
    logic                       bad_q;
    logic [FRAME_DATA_SYMS-1:0] dbuf_q;
    logic [FRAME_DATA_SYMS-1:0] prev_data_q;
    logic                       prev_valid_q;
    logic [2:0]                 match_cnt_q;
    logic                       confirm_q;
    logic [3:0]                 d_q;
    logic                       dv_q;
    logic                       frame_err_q;

    logic       is_sync;
    logic       sym_ok_d;
    logic       good_d;
    logic       same_d;
    logic [2:0] match_cnt_d;
    logic       expired;

    assign is_sync = (sym_code == SYM_SYNC);

    // Address trits occupy idx 0..7 (bit 3 clear); data symbols occupy idx 8..11.
    always_comb begin
        sym_ok_d = 1'b1;
        if (!idx_q[3]) begin
            sym_ok_d = trit_match(sym_code, addr_val[idx_q[2:0]], addr_f[idx_q[2:0]]);
        end else begin
            sym_ok_d = (sym_code == SYM_0) || (sym_code == SYM_1);
        end
    end

    always_comb begin
        good_d      = !bad_q;
        same_d      = prev_valid_q && (dbuf_q == prev_data_q);
        match_cnt_d = '0;
        if (good_d) begin
            if (same_d) begin
                match_cnt_d = (match_cnt_q == CONF) ? match_cnt_q : match_cnt_q + 1'b1;
            end else begin
                match_cnt_d = 3'd1;
            end
        end
    end

    pt2272_hold_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_hold_timer (
        .osc_clk(osc_clk),
        .reset  (reset),
        .reload (confirm_q),
        .run    (dv_q),
        .expired(expired)
    );

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            bad_q        <= 1'b0;
            dbuf_q       <= '0;
            prev_data_q  <= '0;
            prev_valid_q <= 1'b0;
            match_cnt_q  <= '0;
            confirm_q    <= 1'b0;
            d_q          <= '0;
            dv_q         <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            confirm_q   <= 1'b0;

            if (confirm_q) begin
                dv_q <= 1'b1;
                d_q  <= prev_data_q;
            end else if (expired) begin
                dv_q         <= 1'b0;
                match_cnt_q  <= '0;
                prev_valid_q <= 1'b0;
                if (!LATCH) d_q <= '0;
            end

            // Frame evaluation below is written later so it overrides an expiry clear on the same edge.
            case (state_q)
                HUNT: begin
                    if (sym_valid && is_sync) begin
                        state_q <= COLLECT;
                        idx_q   <= '0;
                        bad_q   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (sym_valid) begin
                        if (is_sync) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                            bad_q       <= 1'b0;
                        end else begin
                            if (!sym_ok_d) bad_q <= 1'b1;
                            if (idx_q[3] && sym_ok_d) dbuf_q[idx_q[1:0]] <= sym_code[0];
                            if (idx_q == LAST_IDX) begin
                                state_q <= TAIL;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (sym_valid) begin
                        if (is_sync) begin
                            if (!good_d) frame_err_q <= 1'b1;
                            match_cnt_q  <= match_cnt_d;
                            prev_valid_q <= good_d;
                            if (good_d && !same_d) prev_data_q <= dbuf_q;
                            confirm_q    <= good_d && (match_cnt_d == CONF);
                            state_q      <= COLLECT;
                            idx_q        <= '0;
                            bad_q        <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= HUNT;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign D         = d_q;
    assign dv        = dv_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == COLLECT) || (state_q == TAIL);

endmodule

// File: tb/tb_pt2272_frame_sequencer.sv
// Directed bench: two sequencer instances (LATCH=0 and LATCH=1) share one symbol stream.
module tb_pt2272_frame_sequencer;
    import pt2272_pkg::*;

    localparam int unsigned TMO = 100;

    logic       osc_clk = 1'b0;
    logic       reset;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic [7:0] addr_val;
    logic [7:0] addr_f;
    logic [3:0] d0, d1;
    logic       dv0, dv1, fe0, fe1, busy0, busy1;

    int total = 0;
    int bad   = 0;
    bit mon   = 1'b0;

    always #5 osc_clk = ~osc_clk;

    pt2272_frame_sequencer #(
        .CONFIRM_FRAMES(2),
        .TIMEOUT_CYC   (TMO),
        .LATCH         (1'b0)
    ) dut0 (
        .osc_clk  (osc_clk),
        .reset    (reset),
        .sym_valid(sym_valid),
        .sym_code (sym_code),
        .addr_val (addr_val),
        .addr_f   (addr_f),
        .D        (d0),
        .dv       (dv0),
        .frame_err(fe0),
        .busy     (busy0)
    );

    pt2272_frame_sequencer #(
        .CONFIRM_FRAMES(2),
        .TIMEOUT_CYC   (TMO),
        .LATCH         (1'b1)
    ) dut1 (
        .osc_clk  (osc_clk),
        .reset    (reset),
        .sym_valid(sym_valid),
        .sym_code (sym_code),
        .addr_val (addr_val),
        .addr_f   (addr_f),
        .D        (d1),
        .dv       (dv1),
        .frame_err(fe1),
        .busy     (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // dv must stay high across data changes once established.
    always @(negedge osc_clk) begin
        if (mon) check("dv_hold", {dv1, dv0}, 2'b11);
    end

    // One symbol per call: valid for exactly one rising edge; returns just after that edge.
    task automatic send(input logic [1:0] code);
        @(negedge osc_clk);
        sym_valid = 1'b1;
        sym_code  = code;
        @(negedge osc_clk);
        sym_valid = 1'b0;
        sym_code  = SYM_0;
    endtask

    // Eight address trits (trit i at bits 2i+1:2i) then D0..D3; no SYNC.
    task automatic send_frame(input logic [15:0] acodes, input logic [3:0] data);
        for (int unsigned i = 0; i < 8; i++) send(acodes[2*i +: 2]);
        for (int unsigned i = 0; i < 4; i++) send(data[i] ? SYM_1 : SYM_0);
    endtask

    initial begin
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_code  = SYM_0;
        addr_val  = 8'h00;
        addr_f    = 8'h00;
        repeat (2) @(negedge osc_clk);
        check("rst_D", {d1, d0}, 8'h00);
        check("rst_flags", {dv1, dv0, fe1, fe0, busy1, busy0}, 6'b0);
        reset = 1'b0;

        // Junk before SYNC is dropped silently.
        send(SYM_1);
        check("hunt_drop", {fe1, fe0, busy1, busy0}, 4'b0);

        // Two identical frames confirm at the third SYNC.
        send(SYM_SYNC);
        check("busy_collect", {busy1, busy0}, 2'b11);
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        check("fe_good1", {fe1, fe0}, 2'b00);
        @(negedge osc_clk);
        check("no_dv_first", {dv1, dv0}, 2'b00);
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        check("dv_latency", {dv1, dv0}, 2'b00);
        @(negedge osc_clk);
        check("dv_conf", {dv1, dv0}, 2'b11);
        check("D_conf", {d1, d0}, 8'h55);

        // Hold timeout: dv high for exactly TMO cycles after the confirming edge.
        repeat (TMO - 1) @(negedge osc_clk);
        check("dv_before_tmo", {dv1, dv0}, 2'b11);
        @(negedge osc_clk);
        check("dv_after_tmo", {dv1, dv0}, 2'b00);
        check("D_after_tmo", {d1, d0}, 8'h50);

        // Trit 3 expected floating but sent as 0: rejected frame.
        addr_f = 8'h08;
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        check("fe_addr", {fe1, fe0}, 2'b11);
        @(negedge osc_clk);
        check("fe_pulse_end", {fe1, fe0}, 2'b00);
        check("dv_addr_bad", {dv1, dv0}, 2'b00);
        addr_f = 8'h00;
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("cnt_cleared", {dv1, dv0}, 2'b00);

        // SYNC at idx5 aborts the frame and starts a new one.
        for (int unsigned i = 0; i < 5; i++) send(SYM_0);
        send(SYM_SYNC);
        check("fe_early_sync", {fe1, fe0}, 2'b11);
        send_frame(16'h0000, 4'b1001);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("no_dv_new1", {dv1, dv0}, 2'b00);
        send_frame(16'h0000, 4'b1001);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("dv_restart", {dv1, dv0}, 2'b11);
        check("D_restart", {d1, d0}, 8'h99);
        mon = 1'b1;

        // Data changes while dv is high need fresh confirmation.
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("D_keep_old", {d1, d0}, 8'h99);
        send_frame(16'h0000, 4'b0101);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("D_0101", {d1, d0}, 8'h55);
        send_frame(16'h0000, 4'b0011);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("D_hold_0101", {d1, d0}, 8'h55);
        send_frame(16'h0000, 4'b0011);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("D_0011", {d1, d0}, 8'h33);
        mon = 1'b0;

        // Reset mid-COLLECT at idx6.
        for (int unsigned i = 0; i < 6; i++) send(SYM_0);
        check("busy_mid", {busy1, busy0}, 2'b11);
        reset = 1'b1;
        #1;
        check("rst_mid_D", {d1, d0}, 8'h00);
        check("rst_mid_flags", {dv1, dv0, busy1, busy0}, 4'b0);
        @(negedge osc_clk);
        reset = 1'b0;
        send(SYM_0);
        send(SYM_0);
        check("hunt_after_rst", {busy1, busy0, fe1, fe0}, 4'b0);

        // Mixed address: trit3 floating, trits 5 and 7 fixed at 1.
        addr_f   = 8'h08;
        addr_val = 8'hA0;
        send(SYM_SYNC);
        send_frame(16'hCC80, 4'b0110);
        send(SYM_SYNC);
        check("fe_mixed", {fe1, fe0}, 2'b00);
        send_frame(16'hCC80, 4'b0110);
        send(SYM_SYNC);
        @(negedge osc_clk);
        check("dv_mixed", {dv1, dv0}, 2'b11);
        check("D_mixed", {d1, d0}, 8'h66);

        // Non-SYNC after D3 is a tail error and returns to HUNT.
        send_frame(16'hCC80, 4'b0110);
        send(SYM_1);
        check("fe_tail", {fe1, fe0}, 2'b11);
        check("busy_tail_err", {busy1, busy0}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
